shift_reg_monitor: RTL
======================

Name: shift_reg_monitor

Overview:
- Reader side of the rotating one-hot LED shift register.
- Samples the register bus on each valid strobe and decodes the lit position.
- Infers rotation direction, counts full revolutions (laps), and flags illegal patterns or jumps.
- Sits beside the shift register, feeding status LEDs and debug observation.

Parameters:
- NB_SHIFT, 4: width of the observed register; legal range NB_SHIFT >= 3.
- NB_INDEX, 2: width of the decoded index; must equal ceil(log2(NB_SHIFT)).
- NB_LAPS, 8: lap counter width; the counter wraps modulo 2^NB_LAPS.
- NB_ERR, 4: error counter width; the counter saturates.

Ports:
- clock  in  1  system clock, all state updates on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  sample strobe, asserted the cycle after the shift register updates.
- i_register  in  NB_SHIFT  observed register value.
- o_index  out  NB_INDEX  position of the lit bit, from the last legal sample.
- o_dir  out  1  rotation direction: 1 = left (bit k to bit k+1), 0 = right.
- o_dir_valid  out  1  o_dir is meaningful.
- o_locked  out  1  monitor is in TRACK.
- o_laps  out  NB_LAPS  count of wrap crossings.
- o_error  out  1  one-cycle pulse on an illegal sample.
- o_err_count  out  NB_ERR  saturating count of illegal samples.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE.
  - All outputs = 0.
  - Stored previous index = 0.
- Timing:
  - Sampling occurs only on rising edges where i_valid = 1.
  - All outputs are registered; a sample is reflected on outputs the cycle after its edge (latency 1).
  - With i_valid = 0, all state and outputs hold, except o_error, which returns to 0.
- Sample classification (prev = stored index, new = decoded index, mod N = NB_SHIFT):
  - Illegal pattern: popcount of i_register != 1 (all zeros, or multiple bits set).
  - Stall: new == prev.
  - Step left: new == (prev + 1) mod N.
  - Step right: new == (prev - 1) mod N.
  - Jump: any other legal one-hot sample.
  - Wrap left: prev = N-1 and new = 0. Wrap right: prev = 0 and new = N-1.
- States:
  - IDLE: no reference yet.
    - Legal sample: store index, go to ACQUIRE.
    - Illegal pattern: go to FAULT.
  - ACQUIRE: reference held, direction unknown.
    - Stall: stay in ACQUIRE.
    - Step: set o_dir, set o_dir_valid = 1, set o_locked = 1, go to TRACK.
    - Jump: treated as an error.
    - Illegal pattern: treated as an error.
  - TRACK:
    - Step: update o_dir every time; a reversal is legal and keeps the block in TRACK.
    - Stall: permitted, no change.
    - Jump or illegal pattern: treated as an error.
  - FAULT:
    - Legal one-hot sample: store index, go to ACQUIRE.
    - Illegal pattern: stay in FAULT.
    - Jumps are not checked in FAULT.
- Error handling, on any jump or illegal pattern, in any state:
  - o_error = 1 for one cycle.
  - o_err_count increments and saturates at 2^NB_ERR - 1.
  - o_dir_valid = 0 and o_locked = 0; state goes to FAULT.
  - o_index keeps its last legal value.
- Laps:
  - Increment on any wrap crossing during a step from ACQUIRE or TRACK, in either direction.
  - The count wraps at 2^NB_LAPS.
  - Laps are not cleared by a fault; only reset clears them.
- Boundary conditions:
  - An i_register change while i_valid = 0 is ignored.
  - A reversal that lands exactly on the wrap boundary counts as a lap.
  - At o_err_count saturation, o_error still pulses.

Test Plan (NB_SHIFT = 4):
1. Left rotation:
   - Stimulus: reset, then samples 0001, 0010, 0100, 1000, 0001.
   - Required: o_index = 0, 1, 2, 3, 0; o_dir = 1 with o_dir_valid/o_locked = 1 from the 2nd sample; o_laps = 1 after the 5th sample.
2. Right rotation:
   - Stimulus: samples 0001, 1000, 0100.
   - Required: o_index = 0, 3, 2; o_dir = 0; o_laps = 1 after 1000; no o_error.
3. Reversal and stall:
   - Stimulus: samples 0001, 0010, 0010, 0100, 0010.
   - Required: o_dir = 1, then 0 at the last sample; o_locked stays 1; o_error never asserts.
4. Illegal patterns and recovery:
   - Stimulus: in TRACK, samples 0000, then 0110, then 0100, then 1000.
   - Required: o_error pulses at 0000 and at 0110; o_err_count = 2; o_locked = 0 during the fault; 0100 gives o_index = 2 with o_locked = 0; 1000 gives o_locked = 1, o_dir = 1.
5. Jump:
   - Stimulus: in TRACK at index 0, sample 0100.
   - Required: o_error pulse; o_dir_valid = 0; o_index stays 0; state goes to FAULT.
6. Strobe gating and reset:
   - Stimulus: i_register toggled with i_valid = 0 for 5 cycles; then i_reset asserted asynchronously mid-cycle in TRACK.
   - Required: outputs unchanged during gated cycles; all outputs = 0 immediately on reset, with no clock edge needed.

Source files
------------

// File: rtl/shift_reg_monitor.sv
// shift_reg_monitor: reader side of the rotating one-hot LED shift register.
// Decodes the lit position on each valid strobe and infers the rotation
// direction. It also counts laps (wrap crossings) and flags illegal patterns
// or jumps with a one-cycle pulse and a saturating error counter.
module shift_reg_monitor #(
  parameter int NB_SHIFT = 4,
  parameter int NB_INDEX = 2,
  parameter int NB_LAPS  = 8,
  parameter int NB_ERR   = 4
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_SHIFT-1:0] i_register,
  output logic [NB_INDEX-1:0] o_index,
  output logic                o_dir,
  output logic                o_dir_valid,
  output logic                o_locked,
  output logic [NB_LAPS-1:0]  o_laps,
  output logic                o_error,
  output logic [NB_ERR-1:0]   o_err_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] TRACK   = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(NB_SHIFT - 1);
  localparam logic [NB_ERR-1:0]   ERR_MAX    = '1;

  logic [1:0]          state;
  logic [NB_INDEX-1:0] new_index;
  logic [NB_INDEX-1:0] prev_plus;
  logic [NB_INDEX-1:0] prev_minus;
  logic                one_hot;
  logic                in_run;
  logic                is_stall;
  logic                step_left;
  logic                step_right;
  logic                wrap_cross;
  logic                error_hit;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_hot = (i_register != '0) &&
                   ((i_register & (i_register - NB_SHIFT'(1))) == '0);

  // Priority encoder for the lit bit; only meaningful when one_hot is true.
  always_comb begin
    new_index = '0;
    for (int k = 0; k < NB_SHIFT; k++) begin
      if (i_register[k]) begin
        new_index = NB_INDEX'(k);
      end
    end
  end

  // Neighbours of the stored index, modulo the register width (o_index is
  // the stored reference, since it always holds the last accepted position).
  assign prev_plus  = (o_index == LAST_INDEX) ? '0 : o_index + NB_INDEX'(1);
  assign prev_minus = (o_index == '0) ? LAST_INDEX : o_index - NB_INDEX'(1);

  assign in_run     = (state == ACQUIRE) || (state == TRACK);
  assign is_stall   = one_hot && (new_index == o_index);
  assign step_left  = one_hot && (new_index == prev_plus);
  assign step_right = one_hot && (new_index == prev_minus);
  assign wrap_cross = (step_left && (o_index == LAST_INDEX)) ||
                      (step_right && (o_index == '0));

  // Illegal patterns are errors everywhere; jumps only matter once a
  // reference is held, so IDLE and FAULT accept any one-hot sample.
  assign error_hit = i_valid &&
                     (!one_hot ||
                      (in_run && !is_stall && !step_left && !step_right));

  // State machine and registered outputs; everything updates only on strobes
  // except the error pulse, which always falls back to zero.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      o_index     <= '0;
      o_dir       <= 1'b0;
      o_dir_valid <= 1'b0;
      o_locked    <= 1'b0;
      o_laps      <= '0;
      o_error     <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_error <= 1'b0;
      if (error_hit) begin
        o_error     <= 1'b1;
        o_dir_valid <= 1'b0;
        o_locked    <= 1'b0;
        state       <= FAULT;
        if (o_err_count != ERR_MAX) begin
          o_err_count <= o_err_count + NB_ERR'(1);
        end
      end else if (i_valid) begin
        if (!in_run) begin
          o_index <= new_index;
          state   <= ACQUIRE;
        end else if (step_left || step_right) begin
          o_index     <= new_index;
          o_dir       <= step_left;
          o_dir_valid <= 1'b1;
          o_locked    <= 1'b1;
          state       <= TRACK;
          if (wrap_cross) begin
            o_laps <= o_laps + NB_LAPS'(1);
          end
        end
      end
    end
  end

endmodule
